// File: rtl/pixel_write_arbiter_if.sv
// pixel_write_arbiter_if: valid/ready pixel stream carrying an (x, y, colour) write.
//   master drives valid, x, y, colour and samples ready; slave does the reverse.
interface pixel_write_arbiter_if #(
    parameter int X_WIDTH      = 8,
    parameter int Y_WIDTH      = 7,
    parameter int COLOUR_WIDTH = 3
);
    logic                    valid;
    logic                    ready;
    logic [X_WIDTH-1:0]      x;
    logic [Y_WIDTH-1:0]      y;
    logic [COLOUR_WIDTH-1:0] colour;
    modport master (output valid, x, y, colour, input ready);
    modport slave  (input valid, x, y, colour, output ready);
endinterface

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: merges a background pass then an object pass into one VGA write stream.
//   clock, resetn   : system clock, synchronous active-low reset
//   bg / bg_done    : background pixel stream (slave) and end-of-pass pulse
//   obj / obj_done  : object pixel stream (slave) and end-of-pass pulse
//   vga             : write port to the VGA adapter (master; valid is vga_plot)
//   frame_done      : one-cycle pulse once the frame is fully written
//   drop_count      : saturating count of off-screen pixels discarded since reset
module pixel_write_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int X_WIDTH      = 8,
    parameter int Y_WIDTH      = 7,
    parameter int COLOUR_WIDTH = 3
) (
    input  logic                         clock,
    input  logic                         resetn,
    pixel_write_arbiter_if.slave         bg,
    input  logic                         bg_done,
    pixel_write_arbiter_if.slave         obj,
    input  logic                         obj_done,
    pixel_write_arbiter_if.master        vga,
    output logic                         frame_done,
    output logic [7:0]                   drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = X_WIDTH + Y_WIDTH + COLOUR_WIDTH;

    typedef enum logic [1:0] {BG_PHASE, OBJ_PHASE, DRAIN} state_t;

    state_t                  state, state_next;
    logic [EW-1:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [AW:0]             count;
    logic                    full, empty, bg_fire, obj_fire, clip, push, pop;
    logic [X_WIDTH-1:0]      in_x;
    logic [Y_WIDTH-1:0]      in_y;
    logic [COLOUR_WIDTH-1:0] in_colour;

    assign full  = count == (AW+1)'(FIFO_DEPTH);
    assign empty = count == '0;

    // Only one source can be ready in any state, so a single mux picks the accepted pixel.
    assign bg_fire   = bg.valid && bg.ready;
    assign obj_fire  = obj.valid && obj.ready;
    assign in_x      = obj_fire ? obj.x : bg.x;
    assign in_y      = obj_fire ? obj.y : bg.y;
    assign in_colour = obj_fire ? obj.colour : bg.colour;
    assign clip      = (bg_fire || obj_fire) && (32'(in_x) >= 160 || 32'(in_y) >= 120);
    assign push      = (bg_fire || obj_fire) && !clip;
    assign pop       = !empty && vga.ready;

    assign vga.valid = !empty;
    assign {vga.x, vga.y, vga.colour} = empty ? '0 : mem[rd_ptr];

    // Readies come from registered state only, so a full FIFO stalls the source even if a pop is pending.
    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        bg.ready   = 1'b0;
        obj.ready  = 1'b0;
        unique case (state)
            BG_PHASE: begin
                bg.ready   = !full;
                state_next = bg_done ? OBJ_PHASE : BG_PHASE;
            end
            OBJ_PHASE: begin
                obj.ready  = !full;
                state_next = obj_done ? DRAIN : OBJ_PHASE;
            end
            DRAIN: begin
                frame_done = empty;
                state_next = empty ? BG_PHASE : DRAIN;
            end
            default: state_next = BG_PHASE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= BG_PHASE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            state  <= state_next;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (clip && drop_count != 8'hff)
                drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= {in_x, in_y, in_colour};
    end
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb_pixel_write_arbiter: directed and randomized checks against a queue-based frame model.
module tb_pixel_write_arbiter;
    localparam int DEPTH = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    typedef struct {int x; int y; int c;} pix_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       bg_done = 1'b0;
    logic       obj_done = 1'b0;
    logic       frame_done;
    logic [7:0] drop_count;

    pixel_write_arbiter_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .COLOUR_WIDTH(CW)) bg_if ();
    pixel_write_arbiter_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .COLOUR_WIDTH(CW)) obj_if ();
    pixel_write_arbiter_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .COLOUR_WIDTH(CW)) vga_if ();

    pixel_write_arbiter #(
        .FIFO_DEPTH(DEPTH), .X_WIDTH(XW), .Y_WIDTH(YW), .COLOUR_WIDTH(CW)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .bg(bg_if.slave),
        .bg_done(bg_done),
        .obj(obj_if.slave),
        .obj_done(obj_done),
        .vga(vga_if.master),
        .frame_done(frame_done),
        .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    int   checks = 0;
    int   failures = 0;
    pix_t q[$];
    int   phase = 0;
    int   drops = 0;
    int   frames = 0;
    int   writes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic accept(input int x, input int y, input int c);
        pix_t p;
        if (x >= 160 || y >= 120)
            drops = drops < 255 ? drops + 1 : 255;
        else begin
            p.x = x; p.y = y; p.c = c;
            q.push_back(p);
        end
    endtask

    task automatic step(input bit rn, input bit bv, input int bx, input int by, input int bc, input bit bd,
                        input bit ov, input int ox, input int oy, input int oc, input bit od, input bit vr);
        bit   er_bg, er_obj, was_empty;
        pix_t h;
        @(negedge clock);
        resetn = rn;
        bg_if.valid = bv; bg_if.x = XW'(bx); bg_if.y = YW'(by); bg_if.colour = CW'(bc); bg_done = bd;
        obj_if.valid = ov; obj_if.x = XW'(ox); obj_if.y = YW'(oy); obj_if.colour = CW'(oc); obj_done = od;
        vga_if.ready = vr;
        #1;
        er_bg  = phase == 0 && q.size() < DEPTH;
        er_obj = phase == 1 && q.size() < DEPTH;
        was_empty = q.size() == 0;
        h.x = 0; h.y = 0; h.c = 0;
        if (!was_empty) h = q[0];
        check("bg_ready", bg_if.ready, er_bg);
        check("obj_ready", obj_if.ready, er_obj);
        check("vga_plot", vga_if.valid, !was_empty);
        check("vga_x", vga_if.x, h.x);
        check("vga_y", vga_if.y, h.y);
        check("vga_colour", vga_if.colour, h.c);
        check("frame_done", frame_done, phase == 2 && was_empty);
        check("drop_count", drop_count, drops);
        @(posedge clock);
        if (!rn) begin
            q.delete(); phase = 0; drops = 0;
        end else begin
            if (phase == 2 && was_empty) frames++;
            if (!was_empty && vr) begin void'(q.pop_front()); writes++; end
            if (bv && er_bg) accept(bx, by, bc);
            else if (ov && er_obj) accept(ox, oy, oc);
            case (phase)
                0: if (bd) phase = 1;
                1: if (od) phase = 2;
                default: if (was_empty) phase = 0;
            endcase
        end
    endtask

    task automatic idle(input int n, input bit vr);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, vr);
    endtask

    task automatic bgp(input int x, input int y, input int c, input bit d, input bit vr);
        step(1, 1, x, y, c, d, 0, 0, 0, 0, 0, vr);
    endtask

    task automatic objp(input int x, input int y, input int c, input bit d, input bit vr);
        step(1, 0, 0, 0, 0, 0, 1, x, y, c, d, vr);
    endtask

    initial begin
        int f0, w0;
        bg_if.valid = 0; bg_if.x = 0; bg_if.y = 0; bg_if.colour = 0;
        obj_if.valid = 0; obj_if.x = 0; obj_if.y = 0; obj_if.colour = 0;
        vga_if.ready = 0;
        repeat (3) @(posedge clock);
        idle(1, 0);

        // ordered pass
        f0 = frames; w0 = writes;
        bgp(0, 0, 1, 0, 1);
        bgp(1, 0, 2, 0, 1);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        objp(5, 5, 7, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(4, 1);
        check("pass_frames", frames - f0, 1);
        check("pass_writes", writes - w0, 3);

        // backpressure: six offers with the VGA stalled, then drain
        for (int i = 0; i < 6; i++) bgp(10 + i, 3, i, 0, 0);
        check("bp_held", q.size(), DEPTH);
        idle(8, 1);

        // clipping edges then drop_count saturation
        bgp(160, 0, 1, 0, 1);
        bgp(0, 120, 2, 0, 1);
        bgp(159, 119, 3, 0, 1);
        idle(2, 1);
        check("clip_drops", drop_count, 2);
        for (int i = 0; i < 300; i++) bgp(160 + $urandom_range(95), $urandom_range(127), $urandom_range(7), 0, 1);
        idle(1, 1);
        check("drop_sat", drop_count, 255);

        // phase gating: object offers and object done ignored in background phase
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1, 4, 4, 4, 1, 1);

        // coincident last pixel with bg_done, then full FIFO with push and pop together
        bgp(7, 7, 5, 1, 1);
        for (int i = 0; i < 5; i++) objp(20 + i, 1, i, 0, 0);
        for (int i = 0; i < 4; i++) objp(30 + i, 2, i, 0, 1);
        objp(40, 2, 6, 1, 1);
        idle(8, 1);

        // reset mid-frame with three entries buffered in the object phase
        bgp(1, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) objp(50 + i, 9, i, 0, 0);
        check("pre_reset_fill", q.size(), 4);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3, 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++)
            step($urandom_range(199) != 0,
                 $urandom_range(1), $urandom_range(175), $urandom_range(127), $urandom_range(7), $urandom_range(19) == 0,
                 $urandom_range(1), $urandom_range(175), $urandom_range(127), $urandom_range(7), $urandom_range(19) == 0,
                 $urandom_range(4) < 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
